// File: rtl/trace_checker.sv
// -----------------------------------------------------------------------------
// trace_checker
//
// Character-serial parser and checker for execution-trace records. One ASCII
// character is consumed on every rising clock edge. Two record shapes are
// recognised:
//     register record:  ^T@P: $R <= D#
//     memory record:    ^T@P: *A <= D#
// T is 1..TIME_DIGITS decimal digits, P/A/D are exactly 8 lowercase hex
// digits and R is 1..2 decimal digits. Spaces are allowed only after ':',
// before '<' and after '='. A '^' always restarts parsing from scratch.
//
// On the edge that consumes the closing '#', the record is reported for one
// cycle on format_type, its semantic error flags are latched on error_code,
// and rec_count is incremented.
//
// Ports
//     clk         : sole clock, rising edge
//     reset       : asynchronous, active-low reset
//     char        : ASCII character consumed every rising edge
//     format_type : 0 none, 1 register record, 2 memory record (one cycle)
//     error_code  : {reg, addr, pc, time} flags of the last accepted record
//     rec_count   : number of syntactically valid records since reset
// -----------------------------------------------------------------------------
module trace_checker #(
    parameter int          TIME_DIGITS = 4,
    parameter logic [31:0] PC_MIN      = 32'h0000_3000,
    parameter logic [31:0] PC_MAX      = 32'h0000_4ffc,
    parameter int          REG_MAX     = 31,
    parameter int          CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       char,
    output logic [1:0]       format_type,
    output logic [3:0]       error_code,
    output logic [CNT_W-1:0] rec_count
);

    // Time accumulator is sized to hold 10^TIME_DIGITS - 1.
    localparam int         TIME_W        = $clog2(10 ** TIME_DIGITS);
    localparam logic [4:0] TIME_DIGITS_L = 5'(TIME_DIGITS);
    localparam logic [6:0] REG_MAX_L     = 7'(REG_MAX);

    localparam logic [7:0] CH_CARET = 8'h5e;  // '^'
    localparam logic [7:0] CH_AT    = 8'h40;  // '@'
    localparam logic [7:0] CH_COLON = 8'h3a;  // ':'
    localparam logic [7:0] CH_SPACE = 8'h20;  // ' '
    localparam logic [7:0] CH_DOLL  = 8'h24;  // '$'
    localparam logic [7:0] CH_STAR  = 8'h2a;  // '*'
    localparam logic [7:0] CH_LT    = 8'h3c;  // '<'
    localparam logic [7:0] CH_EQ    = 8'h3d;  // '='
    localparam logic [7:0] CH_HASH  = 8'h23;  // '#'

    // LT waits for '<' (spaces allowed), EQ waits for the '=' directly after it.
    typedef enum logic [3:0] {
        IDLE  = 4'd0,
        TIME  = 4'd1,
        PC    = 4'd2,
        COLON = 4'd3,
        TYPE  = 4'd4,
        REG   = 4'd5,
        ADDR  = 4'd6,
        LT    = 4'd7,
        EQ    = 4'd8,
        DATA  = 4'd9
    } state_t;

    function automatic logic is_dec(input logic [7:0] c);
        return (c >= 8'h30) && (c <= 8'h39);
    endfunction

    // Only lowercase hex digits are legal.
    function automatic logic is_hex(input logic [7:0] c);
        return ((c >= 8'h30) && (c <= 8'h39)) || ((c >= 8'h61) && (c <= 8'h66));
    endfunction

    function automatic logic [3:0] dec_val(input logic [7:0] c);
        logic [7:0] v;
        v = c - 8'h30;
        return v[3:0];
    endfunction

    function automatic logic [3:0] hex_val(input logic [7:0] c);
        logic [7:0] v;
        if (c >= 8'h61) begin
            v = c - 8'h57;
        end else begin
            v = c - 8'h30;
        end
        return v[3:0];
    endfunction

    state_t             state_q,       state_d;
    logic [TIME_W-1:0]  time_q,        time_d;
    logic [TIME_W-1:0]  prev_time_q,   prev_time_d;
    logic [31:0]        pc_q,          pc_d;
    logic [31:0]        addr_q,        addr_d;
    logic [6:0]         reg_q,         reg_d;
    logic [4:0]         cnt_q,         cnt_d;
    logic               mem_q,         mem_d;
    logic               first_q,       first_d;
    logic [1:0]         format_type_q, format_type_d;
    logic [3:0]         error_code_q,  error_code_d;
    logic [CNT_W-1:0]   rec_count_q,   rec_count_d;
    logic [3:0]         rec_err_s;

    // Semantic checks on the fields of the record currently being parsed.
    always_comb begin
        rec_err_s    = 4'b0000;
        rec_err_s[0] = !first_q && (time_q < prev_time_q);
        rec_err_s[1] = (pc_q < PC_MIN) || (pc_q > PC_MAX) || (pc_q[1:0] != 2'b00);
        rec_err_s[2] = mem_q && (addr_q[1:0] != 2'b00);
        rec_err_s[3] = !mem_q && (reg_q > REG_MAX_L);
    end

    // Parser next-state, field accumulation and record acceptance.
    always_comb begin
        state_d       = state_q;
        time_d        = time_q;
        prev_time_d   = prev_time_q;
        pc_d          = pc_q;
        addr_d        = addr_q;
        reg_d         = reg_q;
        cnt_d         = cnt_q;
        mem_d         = mem_q;
        first_d       = first_q;
        format_type_d = 2'd0;
        error_code_d  = error_code_q;
        rec_count_d   = rec_count_q;

        if (char == CH_CARET) begin
            // Resynchronise from any state.
            state_d = TIME;
            time_d  = '0;
            pc_d    = 32'h0000_0000;
            addr_d  = 32'h0000_0000;
            reg_d   = 7'd0;
            cnt_d   = 5'd0;
            mem_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = IDLE;
                end
                TIME: begin
                    if (is_dec(char) && (cnt_q < TIME_DIGITS_L)) begin
                        time_d = (time_q * TIME_W'(4'd10)) + TIME_W'(dec_val(char));
                        cnt_d  = cnt_q + 5'd1;
                    end else if ((char == CH_AT) && (cnt_q != 5'd0)) begin
                        state_d = PC;
                        cnt_d   = 5'd0;
                    end else begin
                        state_d = IDLE;
                    end
                end
                PC: begin
                    if (is_hex(char) && (cnt_q < 5'd8)) begin
                        pc_d  = {pc_q[27:0], hex_val(char)};
                        cnt_d = cnt_q + 5'd1;
                    end else if ((char == CH_COLON) && (cnt_q == 5'd8)) begin
                        state_d = COLON;
                        cnt_d   = 5'd0;
                    end else begin
                        state_d = IDLE;
                    end
                end
                COLON: begin
                    if (char == CH_SPACE) begin
                        state_d = COLON;
                    end else if (char == CH_DOLL) begin
                        state_d = TYPE;
                        mem_d   = 1'b0;
                    end else if (char == CH_STAR) begin
                        state_d = TYPE;
                        mem_d   = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
                TYPE: begin
                    // First digit of R or A; the record type decides the radix.
                    if (!mem_q && is_dec(char)) begin
                        state_d = REG;
                        reg_d   = {3'b000, dec_val(char)};
                        cnt_d   = 5'd1;
                    end else if (mem_q && is_hex(char)) begin
                        state_d = ADDR;
                        addr_d  = {28'h000_0000, hex_val(char)};
                        cnt_d   = 5'd1;
                    end else begin
                        state_d = IDLE;
                    end
                end
                REG: begin
                    if (is_dec(char) && (cnt_q < 5'd2)) begin
                        reg_d = (reg_q * 7'd10) + {3'b000, dec_val(char)};
                        cnt_d = cnt_q + 5'd1;
                    end else if (char == CH_SPACE) begin
                        state_d = LT;
                    end else if (char == CH_LT) begin
                        state_d = EQ;
                    end else begin
                        state_d = IDLE;
                    end
                end
                ADDR: begin
                    if (is_hex(char) && (cnt_q < 5'd8)) begin
                        addr_d = {addr_q[27:0], hex_val(char)};
                        cnt_d  = cnt_q + 5'd1;
                    end else if ((char == CH_SPACE) && (cnt_q == 5'd8)) begin
                        state_d = LT;
                    end else if ((char == CH_LT) && (cnt_q == 5'd8)) begin
                        state_d = EQ;
                    end else begin
                        state_d = IDLE;
                    end
                end
                LT: begin
                    if (char == CH_SPACE) begin
                        state_d = LT;
                    end else if (char == CH_LT) begin
                        state_d = EQ;
                    end else begin
                        state_d = IDLE;
                    end
                end
                EQ: begin
                    if (char == CH_EQ) begin
                        state_d = DATA;
                        cnt_d   = 5'd0;
                    end else begin
                        state_d = IDLE;
                    end
                end
                DATA: begin
                    // Spaces only before the first data digit; D itself is not checked.
                    if ((char == CH_SPACE) && (cnt_q == 5'd0)) begin
                        state_d = DATA;
                    end else if (is_hex(char) && (cnt_q < 5'd8)) begin
                        cnt_d = cnt_q + 5'd1;
                    end else if ((char == CH_HASH) && (cnt_q == 5'd8)) begin
                        state_d       = IDLE;
                        format_type_d = mem_q ? 2'd2 : 2'd1;
                        error_code_d  = rec_err_s;
                        rec_count_d   = rec_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
                        prev_time_d   = time_q;
                        first_d       = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            time_q        <= '0;
            prev_time_q   <= '0;
            pc_q          <= 32'h0000_0000;
            addr_q        <= 32'h0000_0000;
            reg_q         <= 7'd0;
            cnt_q         <= 5'd0;
            mem_q         <= 1'b0;
            first_q       <= 1'b1;
            format_type_q <= 2'd0;
            error_code_q  <= 4'b0000;
            rec_count_q   <= '0;
        end else begin
            state_q       <= state_d;
            time_q        <= time_d;
            prev_time_q   <= prev_time_d;
            pc_q          <= pc_d;
            addr_q        <= addr_d;
            reg_q         <= reg_d;
            cnt_q         <= cnt_d;
            mem_q         <= mem_d;
            first_q       <= first_d;
            format_type_q <= format_type_d;
            error_code_q  <= error_code_d;
            rec_count_q   <= rec_count_d;
        end
    end

    assign format_type = format_type_q;
    assign error_code  = error_code_q;
    assign rec_count   = rec_count_q;

endmodule

// File: tb/tb_trace_checker.sv
// -----------------------------------------------------------------------------
// tb_trace_checker
//
// Self-checking bench for trace_checker. Records are assembled as text from
// chosen field values (optionally corrupted in a way that makes them
// syntactically invalid), streamed one character per clock, and the outputs
// are compared against a record-level reference model that tracks the
// previous accepted time, the first-record flag and the record count.
// -----------------------------------------------------------------------------
module tb_trace_checker;

    localparam int          TD      = 4;
    localparam logic [31:0] PC_MIN  = 32'h0000_3000;
    localparam logic [31:0] PC_MAX  = 32'h0000_4ffc;
    localparam int          REG_MAX = 31;

    logic        clk   = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  char  = 8'h20;
    logic [1:0]  format_type;
    logic [3:0]  error_code;
    logic [15:0] rec_count;

    int          n_checks = 0;
    int          n_fail   = 0;

    // Reference model state
    int          m_prev_t = 0;
    bit          m_first  = 1'b1;
    int          m_count  = 0;
    logic [3:0]  m_err    = 4'b0000;

    trace_checker #(
        .TIME_DIGITS (TD),
        .PC_MIN      (PC_MIN),
        .PC_MAX      (PC_MAX),
        .REG_MAX     (REG_MAX),
        .CNT_W       (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .char        (char),
        .format_type (format_type),
        .error_code  (error_code),
        .rec_count   (rec_count)
    );

    // 100 MHz clock
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present one character, let the DUT consume it, sample 1 ns after the edge.
    task automatic drive(input byte c);
        @(negedge clk);
        char = c;
        @(posedge clk);
        #1;
    endtask

    function automatic string spaces(input int n);
        string s;
        s = "";
        for (int i = 0; i < n; i++) s = {s, " "};
        return s;
    endfunction

    // Assemble a record; corrupt != 0 applies one syntax violation.
    function automatic string build(input bit mem, input int t, input int tdig,
                                    input logic [31:0] p, input logic [31:0] a,
                                    input logic [31:0] d, input int r, input int rdig,
                                    input int sp1, input int sp2, input int sp3,
                                    input int corrupt);
        string ts, ps, ds, rs, fs, rel, tail;
        byte   bad;
        ts = $sformatf("%0d", t);
        while (ts.len() < tdig) ts = {"0", ts};
        ps = $sformatf("%08h", p);
        ds = $sformatf("%08h", d);
        rs = $sformatf("%0d", r);
        while (rs.len() < rdig) rs = {"0", rs};
        fs   = mem ? {"*", $sformatf("%08h", a)} : {"$", rs};
        rel  = "<=";
        tail = "#";
        case (corrupt)
            1: while (ts.len() < TD + 1) ts = {"0", ts};
            2: begin
                bad = byte'(8'h41 + 8'($urandom_range(0, 6)));
                ps.putc($urandom_range(0, 7), bad);
            end
            3: ds = ds.substr(0, 6);
            4: ts = {" ", ts};
            5: begin
                if (mem) begin
                    fs = {fs, "0"};
                end else begin
                    while (rs.len() < 2) rs = {"0", rs};
                    fs = {"$1", rs};
                end
            end
            6: tail = "!";
            7: rel = "< =";
            default: ;
        endcase
        return {"^", ts, "@", ps, ":", spaces(sp1), fs, spaces(sp2), rel, spaces(sp3), ds, tail};
    endfunction

    // Stream a string whose final character may complete a record, and check.
    task automatic run_rec(input string s, input bit valid, input bit mem, input int t,
                           input logic [31:0] p, input logic [31:0] a, input int r);
        logic [3:0] e;
        int         exp_ft;
        e      = 4'b0000;
        exp_ft = 0;
        if (valid) begin
            e[0]     = !m_first && (t < m_prev_t);
            e[1]     = (p < PC_MIN) || (p > PC_MAX) || ((p % 32'd4) != 32'd0);
            e[2]     = mem && ((a % 32'd4) != 32'd0);
            e[3]     = !mem && (r > REG_MAX);
            exp_ft   = mem ? 2 : 1;
            m_prev_t = t;
            m_first  = 1'b0;
            m_count  = (m_count + 1) % 65536;
            m_err    = e;
        end
        for (int i = 0; i < s.len(); i++) begin
            drive(s[i]);
            if (i != s.len() - 1) begin
                check_eq("ft_mid", 32'(format_type), 32'd0);
            end else begin
                check_eq("ft_end", 32'(format_type), 32'(exp_ft));
                check_eq("cnt_end", 32'(rec_count), 32'(m_count));
                if (exp_ft != 0) check_eq("err_end", 32'(error_code), 32'(e));
            end
        end
        drive(8'h20);
        check_eq("ft_one_cycle", 32'(format_type), 32'd0);
        check_eq("err_hold", 32'(error_code), 32'(m_err));
    endtask

    task automatic rand_rec(input int corrupt);
        bit          mem;
        int          t, tdig, r, rdig, k;
        logic [31:0] p, a, d;
        string       s, pre, pool;
        mem = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 1) == 0) begin
            t = $urandom_range(0, 9999);
        end else begin
            t = m_prev_t + $urandom_range(0, 30);
            if (t > 9999) t = 9999;
        end
        s    = $sformatf("%0d", t);
        tdig = $urandom_range(s.len(), TD);
        if ($urandom_range(0, 3) == 0) begin
            p = $urandom;
        end else begin
            p = 32'h2f00 + 32'($urandom_range(0, 32'h2200));
            p = (p / 32'd4) * 32'd4;
            if ($urandom_range(0, 3) == 0) p = p + 32'($urandom_range(1, 3));
        end
        a = $urandom;
        if ($urandom_range(0, 1) == 0) a = (a / 32'd4) * 32'd4;
        d    = $urandom;
        r    = $urandom_range(0, 40);
        rdig = (r < 10) ? $urandom_range(1, 2) : 2;
        s = build(mem, t, tdig, p, a, d, r, rdig, $urandom_range(0, 2),
                  $urandom_range(0, 2), $urandom_range(0, 2), corrupt);
        pre  = "";
        pool = "xq#@:$ 01ab<=*";
        k = $urandom_range(0, 3);
        for (int i = 0; i < k; i++) begin
            pre = {pre, $sformatf("%c", pool[$urandom_range(0, pool.len() - 1)])};
        end
        // Occasionally an abandoned prefix of the same record, resynced by '^'.
        if ($urandom_range(0, 4) == 0) pre = {pre, s.substr(0, $urandom_range(1, s.len() - 2))};
        run_rec({pre, s}, (corrupt == 0), mem, t, p, a, r);
    endtask

    initial begin
        string part;
        int    c;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_ft", 32'(format_type), 32'd0);
        check_eq("rst_err", 32'(error_code), 32'd0);
        check_eq("rst_cnt", 32'(rec_count), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Directed records
        run_rec("^102@00003000: $2 <= 89abcdef#", 1'b1, 1'b0, 102, 32'h3000, 32'h0, 2);
        check_eq("req31_cnt", 32'(rec_count), 32'd1);
        check_eq("req31_err", 32'(error_code), 32'd0);
        run_rec("^110@00003004: *0000008c <= ffffb528#", 1'b1, 1'b1, 110, 32'h3004, 32'h8c, 0);
        check_eq("req32_cnt", 32'(rec_count), 32'd2);
        run_rec("^50@00002ffe: $40 <= 00000000#", 1'b1, 1'b0, 50, 32'h2ffe, 32'h0, 40);
        check_eq("req33_err", 32'(error_code), 32'hb);
        run_rec("^12345@00003000: $1 <= 00000000#", 1'b0, 1'b0, 0, 32'h0, 32'h0, 0);
        check_eq("req34_cnt", 32'(rec_count), 32'd3);
        run_rec({"^10@0000", "^11@00003008: *00000010 <= 0000000A#"}, 1'b0, 1'b0, 0, 32'h0, 32'h0, 0);
        check_eq("req35_cnt", 32'(rec_count), 32'd3);
        run_rec("^110@00004ffc:$31<=00000000#", 1'b1, 1'b0, 110, 32'h4ffc, 32'h0, 31);
        check_eq("edge_legal_err", 32'(error_code), 32'd0);
        run_rec("^0110@00005000:   *00000003   <=00000000#", 1'b1, 1'b1, 110, 32'h5000, 32'h3, 0);
        check_eq("edge_max_err", 32'(error_code), 32'h6);

        // Randomised records, mix of valid and corrupted
        for (int n = 0; n < 300; n++) begin
            c = $urandom_range(0, 13);
            rand_rec((c > 7) ? 0 : c);
        end

        // Asynchronous reset in the middle of DATA
        part = "^200@00003000: $3 <= 1234";
        for (int i = 0; i < part.len(); i++) drive(part[i]);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check_eq("async_rst_ft", 32'(format_type), 32'd0);
        check_eq("async_rst_err", 32'(error_code), 32'd0);
        check_eq("async_rst_cnt", 32'(rec_count), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check_eq("hold_rst_ft", 32'(format_type), 32'd0);
        check_eq("hold_rst_cnt", 32'(rec_count), 32'd0);
        @(negedge clk);
        reset    = 1'b1;
        m_first  = 1'b1;
        m_prev_t = 0;
        m_count  = 0;
        m_err    = 4'b0000;
        run_rec("5678#", 1'b0, 1'b0, 0, 32'h0, 32'h0, 0);
        run_rec("^5@00003010: $7 <= 00000001#", 1'b1, 1'b0, 5, 32'h3010, 32'h0, 7);
        check_eq("req36_cnt", 32'(rec_count), 32'd1);
        check_eq("req36_err", 32'(error_code), 32'd0);

        for (int n = 0; n < 60; n++) begin
            c = $urandom_range(0, 13);
            rand_rec((c > 7) ? 0 : c);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/trace_checker.md
TRACE_CHECKER -- requirements
Module: trace_checker

Interface
REQ-001 SHALL declare parameter TIME_DIGITS, default 4, maximum decimal digits in the time field.
REQ-002 SHALL declare parameter PC_MIN, default 32'h0000_3000, lowest legal PC.
REQ-003 SHALL declare parameter PC_MAX, default 32'h0000_4ffc, highest legal PC.
REQ-004 SHALL declare parameter REG_MAX, default 31, highest legal register number.
REQ-005 SHALL declare parameter CNT_W, default 16, width of the record counter.
REQ-006 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-007 SHALL have port reset, input, 1, asynchronous, active-low (0 = reset).
REQ-008 SHALL have port char, input, 8, ASCII character consumed on every rising edge.
REQ-009 SHALL have port format_type, output, 2, 0 = none, 1 = register record, 2 = memory record.
REQ-010 SHALL have port error_code, output, 4, semantic error flags of the record just accepted.
REQ-011 SHALL have port rec_count, output, CNT_W, number of syntactically valid records since reset.

Function
REQ-012 SHALL accept register records of the form ^T@P: $R <= D# and memory records of the form ^T@P: *A <= D#.
REQ-013 SHALL define the fields as follows: T = 1..TIME_DIGITS decimal digits; P, A, D = exactly 8 hex digits (0-9, a-f lowercase only); R = 1..2 decimal digits.
REQ-014 SHALL permit zero or more spaces (0x20) after ':', before '<', and after '='; spaces are illegal anywhere else.
REQ-015 SHALL implement states IDLE, TIME, PC, COLON, TYPE, REG, ADDR, LT, EQ, DATA.
REQ-016 SHALL move from any state, IDLE included, to TIME with all field accumulators cleared when char is '^' (resynchronisation).
REQ-017 SHALL move to IDLE on any other character that is illegal in the current state, or on a digit-count overflow or underflow.
REQ-018 SHALL, on the edge consuming a '#' in DATA after exactly 8 digits, register format_type = 1 or 2 and error_code, increment rec_count (wrapping at 2^CNT_W), and go to IDLE.
REQ-019 SHALL hold format_type nonzero for exactly one cycle, the cycle following the '#' edge; any later edge clears it to 0.
REQ-020 SHALL hold error_code until the next accepted record, and error_code is meaningful only while format_type != 0.
REQ-021 SHALL set error_code[0] (time) when T is less than the T of the previous accepted record; the first record after reset never sets it; equal T is legal.
REQ-022 SHALL set error_code[1] (pc) when P < PC_MIN, P > PC_MAX, or P[1:0] != 0.
REQ-023 SHALL set error_code[2] (addr) when a memory record has A[1:0] != 0; this bit is always 0 for register records.
REQ-024 SHALL set error_code[3] (reg) when a register record has R > REG_MAX; this bit is always 0 for memory records.
REQ-025 SHALL accumulate T as T*10 + digit, wide enough for 10^TIME_DIGITS - 1, with leading zeros permitted.
REQ-026 SHALL accumulate hex fields as value<<4 | nibble.
REQ-027 SHALL update the stored previous-T only on an accepted record, including records that carry error flags.
REQ-028 SHALL treat a syntactically invalid record as producing no output, leaving rec_count and previous-T unchanged.

Reset
REQ-029 SHALL, while reset = 0, immediately force state IDLE, format_type 0, error_code 0, rec_count 0, previous-T cleared, and the "first record" flag set.
REQ-030 SHALL discard a partially parsed record when reset asserts mid-record, and SHALL require a fresh '^' after reset deasserts.

Verification
REQ-031 SHALL cover: "^102@00003000: $2 <= 89abcdef#" -> format_type 1 for one cycle, error_code 0, rec_count 1.
REQ-032 SHALL cover: "^110@00003004: *0000008c <= ffffb528#" after REQ-031 -> format_type 2, error_code 0, rec_count 2.
REQ-033 SHALL cover: "^50@00002ffe: $40 <= 00000000#" after REQ-032 -> format_type 1, error_code 4'b1011.
REQ-034 SHALL cover: "^12345@00003000: $1 <= 00000000#" with TIME_DIGITS = 4 -> format_type stays 0, rec_count unchanged.
REQ-035 SHALL cover: "^10@0000" followed by "^11@00003008: *00000010 <= 0000000A#" -> the first '^' resyncs, uppercase 'A' rejects the record, format_type 0.
REQ-036 SHALL cover: reset = 0 pulsed asynchronously mid-DATA, then a full valid record -> all outputs 0 during reset, the record is accepted with rec_count 1 and error_code[0] = 0.
